// File: rtl/dmem_ctrl_if.sv
// MEM-stage request/response bundle for dmem_ctrl.
// align_err_o exists only when DMEM_ALIGN_CHECK_EN is defined.
interface dmem_ctrl_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;
  logic        stallreq_o;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        align_err_o;
`endif

  modport master (
    output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    input  mem_data_o, mem_ack_o, stallreq_o
`ifdef DMEM_ALIGN_CHECK_EN
    , align_err_o
`endif
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    output mem_data_o, mem_ack_o, stallreq_o
`ifdef DMEM_ALIGN_CHECK_EN
    , align_err_o
`endif
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory responder for the MEM stage: on-chip RAM, wait-state FSM, stall request.
// Optional misaligned-access trap enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_ctrl #(
  parameter int AW          = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES - 1);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ack_q, ack_d;

  logic            from_in_s;
  logic            acc_we_s;
  logic [3:0]      acc_sel_s;
  logic [AW-1:0]   acc_idx_s;
  logic [31:0]     acc_wdata_s;
  logic            enter_ack_s;
  logic            misalign_s;
  logic            ram_we_s;
  logic            unused_s;

  logic [31:0]     ram [2**AW];

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0]      lo_q, lo_d;
  logic [1:0]      acc_lo_s;
  logic            align_q, align_d;

  function automatic logic is_misaligned(input logic [3:0] sel, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if ((sel == 4'b1111) && (lo != 2'b00)) begin
      bad = 1'b1;
    end else if (((sel == 4'b0011) || (sel == 4'b1100)) && lo[0]) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction
`endif

  // Upper address bits are don't-care (wrap); the low two only matter for the alignment trap.
  assign unused_s = ^bus.mem_addr_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q    <= 2'd0;
      align_q <= 1'b0;
    end else begin
      lo_q    <= lo_d;
      align_q <= align_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
    lo_d    = lo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.mem_ce_i) begin
          we_d    = bus.mem_we_i;
          sel_d   = bus.mem_sel_i;
          idx_d   = bus.mem_addr_i[AW+1:2];
          wdata_d = bus.mem_data_i;
`ifdef DMEM_ALIGN_CHECK_EN
          lo_d    = bus.mem_addr_i[1:0];
`endif
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // A dropped request is a pipeline flush: abandon without touching RAM.
        if (!bus.mem_ce_i) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd0) begin
          state_d = S_ACK;
        end else begin
          cnt_d   = cnt_q - 3'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // With zero wait states the access completes straight from IDLE, before the latches are loaded.
  always_comb begin
    from_in_s = (state_q == S_IDLE);
    if (from_in_s) begin
      acc_we_s    = bus.mem_we_i;
      acc_sel_s   = bus.mem_sel_i;
      acc_idx_s   = bus.mem_addr_i[AW+1:2];
      acc_wdata_s = bus.mem_data_i;
    end else begin
      acc_we_s    = we_q;
      acc_sel_s   = sel_q;
      acc_idx_s   = idx_q;
      acc_wdata_s = wdata_q;
    end
`ifdef DMEM_ALIGN_CHECK_EN
    if (from_in_s) begin
      acc_lo_s = bus.mem_addr_i[1:0];
    end else begin
      acc_lo_s = lo_q;
    end
    misalign_s = is_misaligned(acc_sel_s, acc_lo_s);
`else
    misalign_s = 1'b0;
`endif
  end

  always_comb begin
    enter_ack_s = (state_d == S_ACK) && (state_q != S_ACK);
    ram_we_s    = enter_ack_s && acc_we_s && !misalign_s;
    ack_d       = (state_d == S_ACK);
    if (enter_ack_s && !acc_we_s && !misalign_s) begin
      rdata_d = ram[acc_idx_s];
    end else begin
      rdata_d = rdata_q;
    end
`ifdef DMEM_ALIGN_CHECK_EN
    align_d = enter_ack_s && misalign_s;
`endif
  end

  // RAM is deliberately left out of reset so data survives a pipeline reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel_s[b]) begin
          ram[acc_idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_data_o = rdata_q;
  assign bus.mem_ack_o  = ack_q;
  assign bus.stallreq_o = bus.mem_ce_i && (state_q != S_ACK);
`ifdef DMEM_ALIGN_CHECK_EN
  assign bus.align_err_o = align_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: cycle-level model for a 1-wait-state instance,
// directed literal checks for a 3-wait-state instance (abort case).
module tb_dmem_ctrl;

  localparam int WS_A = 1;
  localparam int WS_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  dmem_ctrl_if if_a ();
  dmem_ctrl_if if_b ();

  dmem_ctrl #(.AW(10), .WAIT_STATES(WS_A)) dut_a (.clk(clk), .rst(rst_n), .bus(if_a));
  dmem_ctrl #(.AW(10), .WAIT_STATES(WS_B)) dut_b (.clk(clk), .rst(rst_n), .bus(if_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ram [1024];
  logic [31:0] exp_data  = 32'd0;
  logic        exp_ack   = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_align = 1'b0;
  bit          chk_en    = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  function automatic bit misaligned(input logic [3:0] sel, input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return ((sel == 4'hF) && (a % 32'd4 != 32'd0)) ||
           (((sel == 4'h3) || (sel == 4'hC)) && (a % 32'd2 != 32'd0));
`else
    return 1'b0;
`endif
  endfunction

  // Per-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check32("a_stall", {31'd0, if_a.stallreq_o}, {31'd0, exp_stall});
      check32("a_ack",   {31'd0, if_a.mem_ack_o},  {31'd0, exp_ack});
      check32("a_data",  if_a.mem_data_o, exp_data);
`ifdef DMEM_ALIGN_CHECK_EN
      check32("a_align", {31'd0, if_a.align_err_o}, {31'd0, exp_align});
`endif
    end
  end

  task automatic a_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if_a.mem_ce_i = 1'b0;
      exp_stall = 1'b0;
      exp_ack   = 1'b0;
      exp_align = 1'b0;
    end
  endtask

  // One access on A: request cycle, WS_A wait cycles, then ACK (or abort in wait cycle abort_at).
  task automatic a_access(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] data, input int abort_at, input bit scramble);
    int i;
    @(posedge clk); #1;
    if_a.mem_ce_i   = 1'b1;
    if_a.mem_we_i   = we;
    if_a.mem_sel_i  = sel;
    if_a.mem_addr_i = addr;
    if_a.mem_data_i = data;
    exp_stall = 1'b1;
    exp_ack   = 1'b0;
    exp_align = 1'b0;
    for (int c = 1; c <= WS_A; c++) begin
      @(posedge clk); #1;
      if (scramble) begin
        if_a.mem_data_i = ~data;
        if_a.mem_addr_i = addr + 32'd4;
        if_a.mem_sel_i  = ~sel;
        if_a.mem_we_i   = ~we;
      end
      if (c == abort_at) begin
        if_a.mem_ce_i = 1'b0;
        exp_stall = 1'b0;
        return;
      end
      exp_stall = 1'b1;
    end
    @(posedge clk); #1;
    exp_stall = 1'b0;
    exp_ack   = 1'b1;
    i = idx_of(addr);
    if (misaligned(sel, addr)) begin
      exp_align = 1'b1;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) m_ram[i][8*b +: 8] = data[8*b +: 8];
      end
    end else begin
      exp_data = m_ram[i];
    end
  endtask

  // Directed access on B with literal handshake expectations.
  task automatic b_access(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] data, input int abort_at);
    @(posedge clk); #1;
    if_b.mem_ce_i   = 1'b1;
    if_b.mem_we_i   = we;
    if_b.mem_sel_i  = sel;
    if_b.mem_addr_i = addr;
    if_b.mem_data_i = data;
    @(negedge clk);
    check32("b_req_stall", {31'd0, if_b.stallreq_o}, 32'd1);
    check32("b_req_ack",   {31'd0, if_b.mem_ack_o},  32'd0);
    for (int c = 1; c <= WS_B; c++) begin
      @(posedge clk); #1;
      if (c == abort_at) begin
        if_b.mem_ce_i = 1'b0;
        @(negedge clk);
        check32("b_abort_stall", {31'd0, if_b.stallreq_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
          check32("b_abort_ack", {31'd0, if_b.mem_ack_o}, 32'd0);
          @(negedge clk);
        end
        return;
      end
      @(negedge clk);
      check32("b_wait_stall", {31'd0, if_b.stallreq_o}, 32'd1);
      check32("b_wait_ack",   {31'd0, if_b.mem_ack_o},  32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check32("b_ack_stall", {31'd0, if_b.stallreq_o}, 32'd0);
    check32("b_ack_ack",   {31'd0, if_b.mem_ack_o},  32'd1);
    @(posedge clk); #1;
    if_b.mem_ce_i = 1'b0;
    @(negedge clk);
    check32("b_post_ack", {31'd0, if_b.mem_ack_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.mem_ce_i = 1'b0; if_a.mem_we_i = 1'b0; if_a.mem_sel_i = 4'd0;
    if_a.mem_addr_i = 32'd0; if_a.mem_data_i = 32'd0;
    if_b.mem_ce_i = 1'b0; if_b.mem_we_i = 1'b0; if_b.mem_sel_i = 4'd0;
    if_b.mem_addr_i = 32'd0; if_b.mem_data_i = 32'd0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_data", if_a.mem_data_o, 32'd0);
    check32("rst_ack",  {31'd0, if_a.mem_ack_o}, 32'd0);
    check32("rst_b_data", if_b.mem_data_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full-word store then load.
    a_access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    a_access(1'b0, 4'hF, 32'h10, 32'h0, 0, 1'b0);
    @(negedge clk);
    check32("pin_deadbeef", if_a.mem_data_o, 32'hDEADBEEF);

    // Byte-lane merges; the first store scrambles inputs after the sample.
    a_access(1'b1, 4'hF, 32'h40, 32'h11223344, 0, 1'b0);
    a_access(1'b1, 4'h1, 32'h40, 32'h000000AA, 0, 1'b1);
    a_access(1'b0, 4'h0, 32'h40, 32'h0, 0, 1'b0);
    @(negedge clk);
    check32("pin_byte", if_a.mem_data_o, 32'h112233AA);
    a_access(1'b1, 4'hC, 32'h40, 32'h55660000, 0, 1'b0);
    a_idle(2);
    a_access(1'b0, 4'h1, 32'h40, 32'h0, 0, 1'b0);
    @(negedge clk);
    check32("pin_half", if_a.mem_data_o, 32'h556633AA);

    // Address wrap.
    a_access(1'b1, 4'hF, 32'h1000, 32'h12345678, 0, 1'b0);
    a_access(1'b0, 4'hF, 32'h0000, 32'h0, 0, 1'b0);
    @(negedge clk);
    check32("pin_wrap", if_a.mem_data_o, 32'h12345678);

    // Abort on A: store dropped in its wait cycle, data unchanged afterwards.
    a_access(1'b1, 4'hF, 32'h10, 32'hFFFFFFFF, 1, 1'b0);
    a_idle(2);
    a_access(1'b0, 4'hF, 32'h10, 32'h0, 0, 1'b0);
    @(negedge clk);
    check32("pin_abort_a", if_a.mem_data_o, 32'hDEADBEEF);

    // Reset in the wait cycle of a load.
    @(posedge clk); #1;
    if_a.mem_ce_i = 1'b1; if_a.mem_we_i = 1'b0; if_a.mem_addr_i = 32'h0;
    exp_stall = 1'b1; exp_ack = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_data = 32'd0;
    @(negedge clk);
    check32("pin_rst_data", if_a.mem_data_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    if_a.mem_ce_i = 1'b0;
    exp_stall = 1'b0;
    a_access(1'b0, 4'hF, 32'h0, 32'h0, 0, 1'b0);
    @(negedge clk);
    check32("pin_rst_reload", if_a.mem_data_o, 32'h12345678);
    a_access(1'b0, 4'hF, 32'h40, 32'h0, 0, 1'b0);
    @(negedge clk);
    check32("pin_rst_ram", if_a.mem_data_o, 32'h556633AA);

    // Misaligned word store to 0x22.
    a_access(1'b1, 4'hF, 32'h20, 32'h01020304, 0, 1'b0);
    a_access(1'b1, 4'hF, 32'h22, 32'hCAFEF00D, 0, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    @(negedge clk);
    check32("pin_align_err", {31'd0, if_a.align_err_o}, 32'd1);
`endif
    a_access(1'b0, 4'hF, 32'h20, 32'h0, 0, 1'b0);
    @(negedge clk);
`ifdef DMEM_ALIGN_CHECK_EN
    check32("pin_align_word", if_a.mem_data_o, 32'h01020304);
`else
    check32("pin_align_word", if_a.mem_data_o, 32'hCAFEF00D);
`endif
    a_idle(2);

    // Instance B: three wait states, abort in the second wait cycle.
    b_access(1'b1, 4'hF, 32'h20, 32'hA5A5A5A5, 0);
    b_access(1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, 2);
    check32("b_data_after_abort", if_b.mem_data_o, 32'd0);
    b_access(1'b0, 4'hF, 32'h20, 32'h0, 0);
    check32("pin_abort_b", if_b.mem_data_o, 32'hA5A5A5A5);

    a_idle(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
